// File: rtl/instr_issue_if.sv
// Host-to-buffer handshake and buffer-to-core issue signals for instr_issue_ctrl.
interface instr_issue_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  host_valid;
   logic [DATA_WIDTH-1:0] host_instr;
   logic                  host_ready;
   logic [DATA_WIDTH-1:0] core_instr;
   logic                  core_issue;

   modport master (
      output host_valid, host_instr,
      input  host_ready, core_instr, core_issue
   );

   modport slave (
      input  host_valid, host_instr,
      output host_ready, core_instr, core_issue
   );
endinterface

// File: rtl/instr_issue_ctrl.sv
// Buffers host instruction words and issues them to a core one per cycle,
// dropping illegal opcodes, with IDLE/RUN/DRAIN/HALT sequencing.
module instr_issue_ctrl #(
   parameter int unsigned          DATA_WIDTH = 32,
   parameter int unsigned          DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013)
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         start,
   input  logic         halt_req,
   instr_issue_if.slave bus,
   output logic         busy,
   output logic [15:0]  issue_count,
   output logic         err_opcode
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [CNT_W-1:0]      r_count;
   logic [DATA_WIDTH-1:0] r_core_instr;
   logic                  r_core_issue;
   logic [15:0]           r_issue_count;
   logic                  r_err_opcode;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_ready;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_legal;
   logic                  w_clr_cnt;
   logic [DATA_WIDTH-1:0] w_head;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_ready = !w_full && ((r_state == S_IDLE) || (r_state == S_RUN));
   assign w_push  = bus.host_valid && w_ready;
   assign w_pop   = !w_empty && ((r_state == S_RUN) || (r_state == S_DRAIN));
   assign w_head  = r_mem[r_rptr];

   // Opcode whitelist: addi, add, beq, jal.
   always_comb begin
      w_legal = 1'b0;
      case (w_head[6:0])
         7'b0010011, 7'b0110011, 7'b1100011, 7'b1101111: w_legal = 1'b1;
         default:                                         w_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!arst_n) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clr_cnt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (halt_req)   w_state_nxt = S_HALT;
            else if (start) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (halt_req) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_empty) w_state_nxt = S_HALT;
         end
         S_HALT: begin
            if (start) begin
               w_state_nxt = S_IDLE;
               w_clr_cnt   = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Storage array carries no reset; occupancy and pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= bus.host_instr;
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Issue stage: one-cycle latency from pop to core_instr/core_issue.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         r_core_instr  <= NOP_INSTR;
         r_core_issue  <= 1'b0;
         r_issue_count <= '0;
         r_err_opcode  <= 1'b0;
      end else begin
         r_core_instr <= (w_pop && w_legal) ? w_head : NOP_INSTR;
         r_core_issue <= w_pop && w_legal;
         if (w_pop && !w_legal) r_err_opcode <= 1'b1;
         if (w_clr_cnt)
            r_issue_count <= '0;
         else if (w_pop && w_legal && (r_issue_count != 16'hFFFF))
            r_issue_count <= r_issue_count + 16'd1;
      end
   end

   assign bus.host_ready = w_ready;
   assign bus.core_instr = r_core_instr;
   assign bus.core_issue = r_core_issue;
   assign busy           = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign issue_count    = r_issue_count;
   assign err_opcode     = r_err_opcode;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Self-checking bench for instr_issue_ctrl: vector table plus hand-written
// sequences, with an issue-order scoreboard queue.
module tb_instr_issue_ctrl;

   localparam int unsigned DW  = 32;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        start;
   logic        halt_req;
   logic        busy;
   logic [15:0] issue_count;
   logic        err_opcode;

   instr_issue_if #(.DATA_WIDTH(DW)) bus ();

   instr_issue_ctrl #(.DATA_WIDTH(DW), .DEPTH(4), .NOP_INSTR(NOP)) dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .start       (start),
      .halt_req    (halt_req),
      .bus         (bus),
      .busy        (busy),
      .issue_count (issue_count),
      .err_opcode  (err_opcode)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               n;
      logic [3:0][31:0] w;
      logic [3:0]       iss;
      logic [3:0]       errp;
      logic [15:0]      cnt;
      logic             err;
   } vec_t;

   vec_t        vecs [4];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one edge, then score whatever the core port shows.
   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.core_issue === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_issue: got %h expected no issue", bus.core_instr);
         end else begin
            chk("issue_word", bus.core_instr, exp_q.pop_front());
         end
      end else begin
         chk("nop_word", bus.core_instr, NOP);
      end
   endtask

   task automatic do_reset();
      arst_n         = 1'b0;
      start          = 1'b0;
      halt_req       = 1'b0;
      bus.host_valid = 1'b0;
      bus.host_instr = '0;
      exp_q.delete();
      tick();
      arst_n = 1'b1;
   endtask

   task automatic push(input logic [31:0] w, input logic exp_rdy, input logic exp_issue);
      bus.host_valid = 1'b1;
      bus.host_instr = w;
      chk("host_ready_push", 32'(bus.host_ready), 32'(exp_rdy));
      if (exp_rdy && exp_issue) exp_q.push_back(w);
      tick();
      bus.host_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      logic [3:0] obs;
      logic [3:0] eobs;

      vecs[0] = '{n: 4, w: {32'h008000EF, 32'h00000463, 32'h00208133, 32'h00500093},
                  iss: 4'b1111, errp: 4'b0000, cnt: 16'd4, err: 1'b0};
      vecs[1] = '{n: 3, w: {32'h0, 32'h00000013, 32'h0000007F, 32'h00000013},
                  iss: 4'b0101, errp: 4'b0110, cnt: 16'd2, err: 1'b1};
      vecs[2] = '{n: 4, w: {32'h00000003, 32'h0000006F, 32'h00000063, 32'h00000033},
                  iss: 4'b0111, errp: 4'b1000, cnt: 16'd3, err: 1'b1};
      vecs[3] = '{n: 2, w: {32'h0, 32'h0, 32'h00000013, 32'h0000007F},
                  iss: 4'b0010, errp: 4'b0011, cnt: 16'd1, err: 1'b1};

      // Reset state
      do_reset();
      chk("rst_core_issue", 32'(bus.core_issue), 32'd0);
      chk("rst_issue_count", 32'(issue_count), 32'd0);
      chk("rst_err", 32'(err_opcode), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_host_ready", 32'(bus.host_ready), 32'd1);

      // Preload-and-run vectors
      for (int v = 0; v < 4; v++) begin
         do_reset();
         for (int i = 0; i < vecs[v].n; i++) push(vecs[v].w[i], 1'b1, vecs[v].iss[i]);
         pulse_start();
         chk("busy_run", 32'(busy), 32'd1);
         obs  = '0;
         eobs = '0;
         for (int i = 0; i < vecs[v].n; i++) begin
            tick();
            obs[i]  = bus.core_issue;
            eobs[i] = err_opcode;
         end
         chk("issue_pattern", 32'(obs), 32'(vecs[v].iss));
         chk("err_pattern", 32'(eobs), 32'(vecs[v].errp));
         tick();
         tick();
         chk("queue_drained", 32'(exp_q.size()), 32'd0);
         chk("vec_issue_count", 32'(issue_count), 32'(vecs[v].cnt));
         chk("vec_err", 32'(err_opcode), 32'(vecs[v].err));
      end

      // Full buffer: fifth word refused, only four issued
      do_reset();
      for (int i = 0; i < 5; i++) push(32'h00000093 | (32'(i) << 20), (i < 4), 1'b1);
      chk("full_ready", 32'(bus.host_ready), 32'd0);
      pulse_start();
      chk("full_ready_with_pop", 32'(bus.host_ready), 32'd0);
      for (int i = 0; i < 6; i++) tick();
      chk("full_drained", 32'(exp_q.size()), 32'd0);
      chk("full_count", 32'(issue_count), 32'd4);

      // Halt drain with three buffered words
      do_reset();
      for (int i = 0; i < 3; i++) push(32'h00000033 | (32'(i + 1) << 7), 1'b1, 1'b1);
      pulse_start();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("drain_ready", 32'(bus.host_ready), 32'd0);
      chk("drain_busy", 32'(busy), 32'd1);
      tick();
      tick();
      tick();
      chk("halt_busy", 32'(busy), 32'd0);
      chk("halt_ready", 32'(bus.host_ready), 32'd0);
      chk("halt_count", 32'(issue_count), 32'd3);
      chk("halt_drained", 32'(exp_q.size()), 32'd0);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("halt_ignores_halt", 32'(busy), 32'd0);
      pulse_start();
      chk("idle_count_clr", 32'(issue_count), 32'd0);
      chk("idle_ready", 32'(bus.host_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);

      // halt_req beats start in IDLE
      do_reset();
      start    = 1'b1;
      halt_req = 1'b1;
      tick();
      start    = 1'b0;
      halt_req = 1'b0;
      chk("halt_wins_busy", 32'(busy), 32'd0);
      chk("halt_wins_ready", 32'(bus.host_ready), 32'd0);
      pulse_start();
      chk("halt_wins_to_idle", 32'(bus.host_ready), 32'd1);

      // Streaming in RUN, then drain from empty
      do_reset();
      pulse_start();
      for (int i = 0; i < 10; i++) push(32'h0000006F | (32'(i + 1) << 12), 1'b1, 1'b1);
      tick();
      tick();
      chk("stream_drained", 32'(exp_q.size()), 32'd0);
      chk("stream_count", 32'(issue_count), 32'd10);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("empty_drain_busy", 32'(busy), 32'd1);
      tick();
      chk("empty_drain_halt", 32'(busy), 32'd0);

      // Reset mid-RUN discards buffered words
      do_reset();
      for (int i = 0; i < 3; i++) push(32'h00000063 | (32'(i + 1) << 8), 1'b1, 1'b1);
      pulse_start();
      tick();
      arst_n = 1'b0;
      exp_q.delete();
      tick();
      chk("midrst_issue", 32'(bus.core_issue), 32'd0);
      chk("midrst_count", 32'(issue_count), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      arst_n = 1'b1;
      chk("midrst_ready", 32'(bus.host_ready), 32'd1);
      pulse_start();
      tick();
      tick();
      tick();
      chk("midrst_empty_count", 32'(issue_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
